// File: rtl/sink_lookup_ctrl.sv
// Known-sink lookup sequencer: scans a NUM_SINKS-entry ID table one entry per clock per query.
// Optional macro SINK_SCAN_EARLY_EXIT_EN ends the scan at the first hit instead of always scanning all entries.
module sink_lookup_ctrl #(
    parameter int ID_W      = 5,
    parameter int NUM_SINKS = 10,
    parameter int IDX_W     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [ID_W-1:0]  wr_id,
    input  logic             clr_all,
    input  logic             query_valid,
    input  logic [ID_W-1:0]  query_id,
    output logic             query_ready,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [IDX_W-1:0] resp_idx,
    input  logic             resp_ready,
    output logic             busy
);

`ifdef SINK_SCAN_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SINKS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESP} state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        id_q [NUM_SINKS];
    logic [ID_W-1:0]        id_d [NUM_SINKS];
    logic [NUM_SINKS-1:0]   valid_q, valid_d;
    logic [ID_W-1:0]        query_q, query_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic                   hit_q, hit_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   entry_match;
    logic                   scan_last;

    assign entry_match = valid_q[ptr_q] && (id_q[ptr_q] == query_q);
    assign scan_last   = (ptr_q == LAST_IDX);

    // Table update; out-of-range write indices match no entry and are dropped.
    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        if (clr_all) begin
            valid_d = '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_SINKS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    id_d[i]    = wr_id;
                    valid_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (query_valid) state_d = ST_SCAN;
            ST_SCAN: if (scan_last || (EARLY_EXIT && entry_match)) state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan datapath: hit_q/idx_q keep the first match and double as the response registers.
    always_comb begin
        query_d = query_q;
        ptr_d   = ptr_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (query_valid) begin
                    query_d = query_id;
                    ptr_d   = '0;
                    hit_d   = 1'b0;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                if (entry_match && !hit_q) begin
                    hit_d = 1'b1;
                    idx_d = ptr_q;
                end
                if (!scan_last) ptr_d = ptr_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        query_ready = (state_q == ST_IDLE);
        resp_valid  = (state_q == ST_RESP);
        resp_hit    = (state_q == ST_RESP) && hit_q;
        resp_idx    = (state_q == ST_RESP) ? idx_q : '0;
        busy        = (state_q != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            id_q    <= '{default: '0};
            valid_q <= '0;
            query_q <= '0;
            ptr_q   <= '0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            query_q <= query_d;
            ptr_q   <= ptr_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_sink_lookup_ctrl.sv
// Bench for sink_lookup_ctrl: directed vector table, corner sequences and random queries against a table model.
module tb_sink_lookup_ctrl;

`ifdef SINK_SCAN_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int NS = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_idx;
    logic [4:0] wr_id;
    logic       clr_all;
    logic       query_valid;
    logic [4:0] query_id;
    logic       query_ready;
    logic       resp_valid;
    logic       resp_hit;
    logic [3:0] resp_idx;
    logic       resp_ready;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Model of the table as the design should hold it.
    bit mvalid [16];
    int mid    [16];

    sink_lookup_ctrl dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_id(wr_id),
        .clr_all(clr_all), .query_valid(query_valid), .query_id(query_id),
        .query_ready(query_ready), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_idx(resp_idx), .resp_ready(resp_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic edge_tick();
        if (reset || clr_all) begin
            for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
        end else if (wr_en && int'(wr_idx) < NS) begin
            mvalid[int'(wr_idx)] = 1'b1;
            mid[int'(wr_idx)]    = int'(wr_id);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic write_entry(input int idx, input int id);
        wr_en = 1'b1; wr_idx = 4'(idx); wr_id = 5'(id);
        edge_tick();
        wr_en = 1'b0;
    endtask

    task automatic clear_table();
        clr_all = 1'b1;
        edge_tick();
        clr_all = 1'b0;
    endtask

    // One query: optional write in scan cycle wcyc (1 = first scan cycle), optional resp hold.
    task automatic run_query(input int q, input int wcyc, input int widx, input int wid,
                             input int hold, output int o_hit, output int o_idx, output int o_lat);
        int guard, lat, exp_lat, ptr, midx;
        bit mhit;
        guard = 0;
        while (!query_ready && guard < 30) begin edge_tick(); guard++; end
        query_valid = 1'b1; query_id = 5'(q);
        edge_tick();
        query_valid = 1'b0; query_id = 5'($urandom);
        chk("ready_low_after_accept", int'(query_ready), 0);
        chk("busy_after_accept", int'(busy), 1);
        lat = 0; exp_lat = -1; ptr = 0; mhit = 1'b0; midx = 0;
        while (!resp_valid && lat < 40) begin
            lat++;
            if (exp_lat < 0) begin
                if (mvalid[ptr] && mid[ptr] == q && !mhit) begin mhit = 1'b1; midx = ptr; end
                ptr++;
                if (ptr == NS || (EARLY && mhit)) exp_lat = ptr;
            end
            if (lat == wcyc) begin wr_en = 1'b1; wr_idx = 4'(widx); wr_id = 5'(wid); end
            edge_tick();
            wr_en = 1'b0;
        end
        chk("latency", lat, exp_lat);
        chk("resp_hit_model", int'(resp_hit), int'(mhit));
        chk("resp_idx_model", int'(resp_idx), midx);
        o_hit = int'(resp_hit); o_idx = int'(resp_idx); o_lat = lat;
        for (int h = 0; h < hold; h++) begin
            query_valid = 1'b1; query_id = 5'(q + 1);
            edge_tick();
            chk("hold_resp_valid", int'(resp_valid), 1);
            chk("hold_resp_hit", int'(resp_hit), int'(mhit));
            chk("hold_resp_idx", int'(resp_idx), midx);
            chk("hold_query_ready", int'(query_ready), 0);
        end
        query_valid = 1'b0;
        resp_ready = 1'b1;
        edge_tick();
        resp_ready = 1'b0;
        chk("ready_after_resp", int'(query_ready), 1);
        chk("resp_valid_after_resp", int'(resp_valid), 0);
    endtask

    typedef struct {
        int a_idx, a_id, b_idx, b_id, q, exp_hit, exp_idx;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int hit, idx, lat, seen;

        reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_id = '0; clr_all = 1'b0;
        query_valid = 1'b0; query_id = '0; resp_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin mvalid[i] = 1'b0; mid[i] = 0; end
        edge_tick();
        edge_tick();
        chk("rst_query_ready", int'(query_ready), 1);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_hit", int'(resp_hit), 0);
        chk("rst_resp_idx", int'(resp_idx), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        edge_tick();

        // Empty-table miss.
        run_query(3, 0, 0, 0, 0, hit, idx, lat);
        chk("empty_hit", hit, 0);
        chk("empty_idx", idx, 0);
        chk("empty_lat", lat, 10);

        vecs[0] = '{2, 7, 6, 7, 7, 1, 2};
        vecs[1] = '{9, 31, 12, 31, 31, 1, 9};
        vecs[2] = '{0, 0, 12, 0, 0, 1, 0};
        vecs[3] = '{3, 4, 3, 6, 4, 0, 0};
        vecs[4] = '{1, 5, 0, 5, 5, 1, 0};
        vecs[5] = '{9, 3, 4, 2, 1, 0, 0};
        foreach (vecs[v]) begin
            clear_table();
            write_entry(vecs[v].a_idx, vecs[v].a_id);
            write_entry(vecs[v].b_idx, vecs[v].b_id);
            run_query(vecs[v].q, 0, 0, 0, 0, hit, idx, lat);
            chk($sformatf("vec%0d_hit", v), hit, vecs[v].exp_hit);
            chk($sformatf("vec%0d_idx", v), idx, vecs[v].exp_idx);
            chk($sformatf("vec%0d_lat", v), lat,
                (EARLY && vecs[v].exp_hit == 1) ? vecs[v].exp_idx + 1 : 10);
        end

        // Held response with a competing query request.
        clear_table();
        write_entry(9, 31);
        run_query(31, 0, 0, 0, 5, hit, idx, lat);
        chk("hold_hit", hit, 1);
        chk("hold_idx", idx, 9);

        // Out-of-range write, clear-vs-write priority, query 0 on cleared table.
        clear_table();
        write_entry(12, 20);
        run_query(20, 0, 0, 0, 0, hit, idx, lat);
        chk("oob_write_hit", hit, 0);
        clr_all = 1'b1; wr_en = 1'b1; wr_idx = 4'd0; wr_id = 5'd4;
        edge_tick();
        clr_all = 1'b0; wr_en = 1'b0;
        run_query(4, 0, 0, 0, 0, hit, idx, lat);
        chk("clr_wins_hit", hit, 0);
        run_query(0, 0, 0, 0, 0, hit, idx, lat);
        chk("cleared_q0_hit", hit, 0);

        // Writes landing mid-scan ahead of and behind the pointer.
        clear_table();
        run_query(5, 3, 8, 5, 0, hit, idx, lat);
        chk("midscan_ahead_hit", hit, 1);
        chk("midscan_ahead_idx", idx, 8);
        clear_table();
        run_query(5, 3, 1, 5, 0, hit, idx, lat);
        chk("midscan_behind_hit", hit, 0);

        // Reset in the 4th scan cycle aborts the query and empties the table.
        clear_table();
        write_entry(0, 9);
        query_valid = 1'b1; query_id = 5'd9;
        edge_tick();
        query_valid = 1'b0;
        edge_tick(); edge_tick(); edge_tick();
        reset = 1'b1;
        edge_tick();
        reset = 1'b0;
        chk("abort_query_ready", int'(query_ready), 1);
        chk("abort_resp_valid", int'(resp_valid), 0);
        chk("abort_busy", int'(busy), 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            edge_tick();
            if (resp_valid) seen++;
        end
        chk("abort_no_response", seen, 0);
        run_query(9, 0, 0, 0, 0, hit, idx, lat);
        chk("abort_table_empty", hit, 0);

        // Random traffic against the table model.
        clear_table();
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) == 0) clear_table();
            for (int w = 0; w < int'($urandom_range(0, 3)); w++)
                write_entry(int'($urandom_range(0, 11)), int'($urandom_range(0, 7)));
            run_query(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
                      int'($urandom_range(0, 11)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 2)), hit, idx, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
